cross_product_arbiter: RTL and testbench

//  Shares one pipelined signed cross-product engine among NREQ requesters (fence sorter, inside-tester, etc.).

---
 rtl/cross_product_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cross_product_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cross_product_arbiter.sv
// cross_product_arbiter: round-robin arbiter with burst lock in front of a shared,
// pipelined signed cross-product engine. Results are returned tagged with the
// requester index.
// Optional build macro XPROD_FAST_EN: merges the difference and multiply stages.
// With the macro, latency is 2 cycles; without it, latency is 3 cycles.
module cross_product_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 10,
   parameter int unsigned TAGW = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        lock,
   input  logic [NREQ*6*CW-1:0]   opnd,
   output logic [NREQ-1:0]        gnt,
   output logic                   rsp_valid,
   output logic [TAGW-1:0]        rsp_id,
   output logic [2*CW+2:0]        rsp_data,
   output logic                   rsp_sign
);

   localparam int unsigned OW = 6 * CW;      // one requester's operand slice
   localparam int unsigned DW = CW + 1;      // signed coordinate difference
   localparam int unsigned PW = 2 * CW + 2;  // signed partial product
   localparam int unsigned RW = 2 * CW + 3;  // signed result

   typedef enum logic {ST_ARB, ST_LOCK} state_t;

   state_t          state_q, state_d;
   logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAGW-1:0] owner_q, owner_d;
   logic [TAGW-1:0] scan_idx;
   logic [TAGW-1:0] win_idx;
   logic            win_vld;

   // Unsigned-to-signed difference a - b, one bit wider than the coordinates
   function automatic logic signed [DW-1:0] sub_u(input logic [CW-1:0] a, input logic [CW-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   // Arbiter state: mode, round-robin pointer and lock owner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_ARB;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   // Next-state and grant: keep a live lock owner, otherwise scan from rr_ptr
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      gnt      = '0;
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      if (state_q == ST_LOCK && req[owner_q] && lock[owner_q]) begin
         win_vld = 1'b1;
         win_idx = owner_q;
      end else begin
         state_d = ST_ARB;
         // Walk from the farthest offset down so the nearest request wins last
         for (int j = int'(NREQ) - 1; j >= 0; j--) begin
            scan_idx = TAGW'((int'(rr_ptr_q) + j) % int'(NREQ));
            if (req[scan_idx]) begin
               win_vld = 1'b1;
               win_idx = scan_idx;
            end
         end
         if (win_vld) begin
            rr_ptr_d = TAGW'((int'(win_idx) + 1) % int'(NREQ));
            if (lock[win_idx]) begin
               state_d = ST_LOCK;
               owner_d = win_idx;
            end
         end
      end
      if (win_vld && !reset) gnt[win_idx] = 1'b1;
   end

   logic [OW-1:0]          win_opnd;
   logic [CW-1:0]          ax, ay, bx, by, cx, cy;
   logic signed [DW-1:0]   dx1_c, dy2_c, dx2_c, dy1_c;

   assign win_opnd = opnd[win_idx*OW +: OW];
   assign ax = win_opnd[6*CW-1 -: CW];
   assign ay = win_opnd[5*CW-1 -: CW];
   assign bx = win_opnd[4*CW-1 -: CW];
   assign by = win_opnd[3*CW-1 -: CW];
   assign cx = win_opnd[2*CW-1 -: CW];
   assign cy = win_opnd[CW-1 -: CW];
   assign dx1_c = sub_u(bx, ax);
   assign dy2_c = sub_u(cy, ay);
   assign dx2_c = sub_u(cx, ax);
   assign dy1_c = sub_u(by, ay);

   // Operands feeding the multiply stage
   logic                 m_vld;
   logic [TAGW-1:0]      m_id;
   logic signed [DW-1:0] m_dx1, m_dy2, m_dx2, m_dy1;

`ifdef XPROD_FAST_EN
   assign m_vld = win_vld;
   assign m_id  = win_idx;
   assign m_dx1 = dx1_c;
   assign m_dy2 = dy2_c;
   assign m_dx2 = dx2_c;
   assign m_dy1 = dy1_c;
`else
   // Stage 1: capture the granted requester's coordinate differences
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_vld <= 1'b0;
         m_id  <= '0;
         m_dx1 <= '0;
         m_dy2 <= '0;
         m_dx2 <= '0;
         m_dy1 <= '0;
      end else begin
         m_vld <= win_vld;
         m_id  <= win_idx;
         m_dx1 <= dx1_c;
         m_dy2 <= dy2_c;
         m_dx2 <= dx2_c;
         m_dy1 <= dy1_c;
      end
   end
`endif

   logic                 p_vld;
   logic [TAGW-1:0]      p_id;
   logic signed [PW-1:0] p0, p1;
   logic signed [RW-1:0] res_c;

   // Multiply stage: both cross terms in parallel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_vld <= 1'b0;
         p_id  <= '0;
         p0    <= '0;
         p1    <= '0;
      end else begin
         p_vld <= m_vld;
         p_id  <= m_id;
         p0    <= PW'(m_dx1) * PW'(m_dy2);
         p1    <= PW'(m_dx2) * PW'(m_dy1);
      end
   end

   assign res_c = RW'(p0) - RW'(p1);

   // Result stage: pulse valid, hold id/data between results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_sign  <= 1'b0;
      end else begin
         rsp_valid <= p_vld;
         if (p_vld) begin
            rsp_id   <= p_id;
            rsp_data <= res_c;
            rsp_sign <= res_c[RW-1];
         end
      end
   end

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Bench for cross_product_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level reference of grants and a queue of due results.
module tb_cross_product_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 10;
   localparam int TAGW = 2;
   localparam int RW   = 2 * CW + 3;
   localparam int MAXC = (1 << CW) - 1;
`ifdef XPROD_FAST_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      lock;
   logic [NREQ*6*CW-1:0] opnd;
   logic [NREQ-1:0]      gnt;
   logic                 rsp_valid;
   logic [TAGW-1:0]      rsp_id;
   logic [RW-1:0]        rsp_data;
   logic                 rsp_sign;

   cross_product_arbiter #(.NREQ(NREQ), .CW(CW), .TAGW(TAGW)) dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .opnd(opnd),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_sign(rsp_sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int due; int id; int data; } rsp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   rr      = 0;
   int   owner   = -1;
   int   last_k  = -1;
   int   last_id = 0;
   int   last_data = 0;
   rsp_t q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", tag, cyc, got, got, exp, exp);
      end
   endtask

   task automatic set_op(input int i, input int ax, input int ay, input int bx,
                         input int by, input int cx, input int cy);
      opnd[i*6*CW +: 6*CW] = {CW'(ax), CW'(ay), CW'(bx), CW'(by), CW'(cx), CW'(cy)};
   endtask

   // Reference cross product from the plain integer formula
   function automatic int xp(input int k);
      logic [6*CW-1:0] s;
      int ax, ay, bx, by, cx, cy;
      s  = opnd[k*6*CW +: 6*CW];
      ax = int'(s[6*CW-1 -: CW]);
      ay = int'(s[5*CW-1 -: CW]);
      bx = int'(s[4*CW-1 -: CW]);
      by = int'(s[3*CW-1 -: CW]);
      cx = int'(s[2*CW-1 -: CW]);
      cy = int'(s[CW-1 -: CW]);
      return (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
   endfunction

   // One clock cycle: check grant and response against the reference, then advance
   task automatic step();
      int k;
      logic [NREQ-1:0] eg;
      logic [RW-1:0] ed;
      logic ev;
      @(negedge clk);
      k = -1;
      if (owner >= 0 && req[owner] && lock[owner]) begin
         k = owner;
      end else begin
         owner = -1;
         for (int j = 0; j < NREQ; j++) begin
            if (k < 0 && req[(rr + j) % NREQ]) k = (rr + j) % NREQ;
         end
         if (k >= 0) begin
            rr = (k + 1) % NREQ;
            if (lock[k]) owner = k;
         end
      end
      eg = '0;
      if (k >= 0) eg[k] = 1'b1;
      check("gnt", 32'(gnt), 32'(eg));
      ev = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         ev = 1'b1;
         last_id   = q[0].id;
         last_data = q[0].data;
         void'(q.pop_front());
      end
      ed = RW'(last_data);
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      check("rsp_id", 32'(rsp_id), 32'(last_id));
      check("rsp_data", 32'(rsp_data), 32'(ed));
      check("rsp_sign", 32'(rsp_sign), (last_data < 0) ? 32'd1 : 32'd0);
      if (k >= 0) q.push_back('{cyc + LAT, k, xp(k)});
      last_k = k;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_data", 32'(rsp_data), 32'd0);
      check("rst_sign", 32'(rsp_sign), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rr = 0; owner = -1; last_k = -1; last_id = 0; last_data = 0;
      q.delete();
   endtask

   function automatic int rnd_coord();
      if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) != 0) ? MAXC : 0;
      return int'($urandom_range(0, MAXC));
   endfunction

   task automatic drain();
      req = '0; lock = '0;
      repeat (LAT + 1) step();
   endtask

   logic [RW-1:0] cst;

   initial begin
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      opnd  = '0;
      do_reset();

      // All requesters from reset: 0,1,2,3,0
      for (int i = 0; i < NREQ; i++) set_op(i, i, 2*i, 100+i, 7, 3, 900-i);
      req = '1;
      repeat (5) step();
      drain();

      // Right-angle triangle, counter-clockwise
      set_op(0, 0, 0, 1023, 0, 0, 1023);
      req = 4'b0001;
      step();
      drain();
      cst = RW'(1046529);
      check("t1_data", 32'(rsp_data), 32'(cst));
      check("t1_sign", 32'(rsp_sign), 32'd0);

      // Same with B and C swapped: clockwise
      set_op(0, 0, 0, 0, 1023, 1023, 0);
      req = 4'b0001;
      step();
      drain();
      cst = RW'(-1046529);
      check("t2_data", 32'(rsp_data), 32'(cst));
      check("t2_sign", 32'(rsp_sign), 32'd1);

      // Collinear points
      set_op(0, 5, 5, 10, 10, 20, 20);
      req = 4'b0001;
      step();
      drain();
      check("t2_zero", 32'(rsp_data), 32'd0);

      // Move rr_ptr to 2, then lock requester 2 for 4 cycles against requester 1
      req = 4'b0010;
      step();
      set_op(1, 1, 2, 3, 4, 5, 6);
      set_op(2, 9, 8, 700, 3, 40, 600);
      req = 4'b0110; lock = 4'b0100;
      repeat (4) step();
      req = 4'b0010; lock = 4'b0000;
      repeat (2) step();
      drain();

      // Back-to-back requester 3 with fresh operands each cycle
      req = 4'b1000;
      for (int n = 0; n < 6; n++) begin
         set_op(3, rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord());
         step();
      end
      drain();

      // Reset one cycle after a grant: the in-flight result must vanish
      set_op(0, 1, 1, 50, 1, 1, 50);
      req = 4'b0001;
      step();
      req = '0;
      do_reset();
      repeat (LAT + 2) step();
      req = '1;
      step();
      drain();

      // Random traffic honouring hold-until-granted
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || i == last_k) begin
               req[i]  = ($urandom_range(0, 3) != 0);
               lock[i] = (i == owner) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
               set_op(i, rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord());
            end
         end
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
